// File: rtl/alu_vector_responder_pkg.sv
// Shared ALU constants: RV32 opcode/funct3 encodings and the ALU operation enum.
// Used by ALUdec, ALU and the alu_vector_responder top.
package alu_vector_responder_pkg;

    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;

    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_SLL     = 3'b001;
    localparam logic [2:0] FNC_SLT     = 3'b010;
    localparam logic [2:0] FNC_SLTU    = 3'b011;
    localparam logic [2:0] FNC_XOR     = 3'b100;
    localparam logic [2:0] FNC_SRL_SRA = 3'b101;
    localparam logic [2:0] FNC_OR      = 3'b110;
    localparam logic [2:0] FNC_AND     = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B, ALU_XXX
    } alu_op_e;

endpackage

// File: rtl/alu_vector_responder_if.sv
// Request/response bus of alu_vector_responder; master = vector source/sink, slave = responder.
// With ALU_RESP_CHECK_EN defined the bus also carries the expected-result check signals.
interface alu_vector_responder_if #(
    parameter int TAG_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct;
    logic             req_add_rshift_type;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
`ifdef ALU_RESP_CHECK_EN
    logic [31:0]      req_expected;
    logic             resp_mismatch;
    logic [15:0]      err_count;
`endif

    modport master (
        output req_valid, req_opcode, req_funct, req_add_rshift_type, req_a, req_b, req_tag,
        input  req_ready, resp_valid, resp_data,
`ifdef ALU_RESP_CHECK_EN
        output req_expected,
        input  resp_mismatch, err_count,
`endif
        output resp_ready,
        input  resp_tag
    );

    modport slave (
        input  req_valid, req_opcode, req_funct, req_add_rshift_type, req_a, req_b, req_tag,
        output req_ready, resp_valid, resp_data,
`ifdef ALU_RESP_CHECK_EN
        input  req_expected,
        output resp_mismatch, err_count,
`endif
        input  resp_ready,
        output resp_tag
    );
endinterface

// File: rtl/ALU.sv
// 32-bit RV32 ALU, arithmetic modulo 2^32, shift amount taken from b[4:0].
module ALU
    import alu_vector_responder_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_op,
    output logic [31:0] result
);
    always_comb begin
        result = 32'd0;
        case (alu_op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_COPY_B: result = b;
            default:    result = 32'd0;
        endcase
    end
endmodule

// File: rtl/ALUdec.sv
// Decodes RV32 opcode/funct3/instr[30] into an ALU operation.
// Unknown opcodes decode to ALU_XXX, which the ALU turns into a zero result.
module ALUdec
    import alu_vector_responder_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    input  logic       add_rshift_type,
    output alu_op_e    alu_op
);
    always_comb begin
        alu_op = ALU_XXX;
        case (opcode)
            OPC_ARI_RTYPE, OPC_ARI_ITYPE: begin
                case (funct)
                    // ADDI has no subtract form; instr[30] is immediate data there.
                    FNC_ADD_SUB: alu_op = (opcode == OPC_ARI_RTYPE && add_rshift_type) ? ALU_SUB : ALU_ADD;
                    FNC_SLL:     alu_op = ALU_SLL;
                    FNC_SLT:     alu_op = ALU_SLT;
                    FNC_SLTU:    alu_op = ALU_SLTU;
                    FNC_XOR:     alu_op = ALU_XOR;
                    FNC_SRL_SRA: alu_op = add_rshift_type ? ALU_SRA : ALU_SRL;
                    FNC_OR:      alu_op = ALU_OR;
                    FNC_AND:     alu_op = ALU_AND;
                    default:     alu_op = ALU_XXX;
                endcase
            end
            OPC_LUI:                           alu_op = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE:   alu_op = ALU_ADD;
            default:                           alu_op = ALU_XXX;
        endcase
    end
endmodule

// File: rtl/alu_resp_fifo.sv
// Synchronous FIFO with combinational head output; DEPTH must be a power of two >= 2.
module alu_resp_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !do_pop)      count_d = count_q + 1'b1;
        else if (!push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];
endmodule

// File: rtl/alu_vector_responder.sv
// ALU test-vector responder: S1 request register -> ALUdec/ALU -> in-order response FIFO.
// Define ALU_RESP_CHECK_EN to carry an expected result and count popped mismatches.
module alu_vector_responder
    import alu_vector_responder_pkg::*;
#(
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_vector_responder_if.slave bus
);
    localparam int CW = $clog2(RESP_DEPTH) + 1;
`ifdef ALU_RESP_CHECK_EN
    localparam int FW = 64 + TAG_W;
`else
    localparam int FW = 32 + TAG_W;
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [6:0]       s1_opcode_q, s1_opcode_d;
    logic [2:0]       s1_funct_q, s1_funct_d;
    logic             s1_type_q, s1_type_d;
    logic [31:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    alu_op_e          alu_op;
    logic [31:0]      alu_result;
    logic [CW-1:0]    count;
    logic [FW-1:0]    push_data, head;
    logic             accept, pop;
`ifdef ALU_RESP_CHECK_EN
    logic [31:0]      s1_expected_q, s1_expected_d;
    logic [15:0]      err_count_q, err_count_d;
`endif

    // S1 reserves its FIFO slot at accept time, so a same-cycle pop is deliberately not credited.
    assign bus.req_ready = (count + CW'(s1_valid_q)) < CW'(RESP_DEPTH);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        s1_valid_d  = accept;
        s1_opcode_d = s1_opcode_q;
        s1_funct_d  = s1_funct_q;
        s1_type_d   = s1_type_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
`ifdef ALU_RESP_CHECK_EN
        s1_expected_d = s1_expected_q;
`endif
        if (accept) begin
            s1_opcode_d = bus.req_opcode;
            s1_funct_d  = bus.req_funct;
            s1_type_d   = bus.req_add_rshift_type;
            s1_a_d      = bus.req_a;
            s1_b_d      = bus.req_b;
            s1_tag_d    = bus.req_tag;
`ifdef ALU_RESP_CHECK_EN
            s1_expected_d = bus.req_expected;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_valid_q <= 1'b0;
        else        s1_valid_q <= s1_valid_d;
    end

    always_ff @(posedge clk) begin
        s1_opcode_q <= s1_opcode_d;
        s1_funct_q  <= s1_funct_d;
        s1_type_q   <= s1_type_d;
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_tag_q    <= s1_tag_d;
`ifdef ALU_RESP_CHECK_EN
        s1_expected_q <= s1_expected_d;
`endif
    end

    ALUdec u_aludec (
        .opcode          (s1_opcode_q),
        .funct           (s1_funct_q),
        .add_rshift_type (s1_type_q),
        .alu_op          (alu_op)
    );

    ALU u_alu (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .alu_op (alu_op),
        .result (alu_result)
    );

`ifdef ALU_RESP_CHECK_EN
    assign push_data = {s1_expected_q, alu_result, s1_tag_q};
`else
    assign push_data = {alu_result, s1_tag_q};
`endif

    alu_resp_fifo #(.WIDTH(FW), .DEPTH(RESP_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid_q),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign bus.resp_valid = (count != '0);
    assign bus.resp_data  = head[TAG_W +: 32];
    assign bus.resp_tag   = head[TAG_W-1:0];
    assign pop            = bus.resp_valid && bus.resp_ready;

`ifdef ALU_RESP_CHECK_EN
    assign bus.resp_mismatch = (head[FW-1 -: 32] != head[TAG_W +: 32]);

    always_comb begin
        err_count_d = err_count_q;
        if (pop && bus.resp_mismatch && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count_q <= 16'd0;
        else        err_count_q <= err_count_d;
    end

    assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_alu_vector_responder.sv
// Randomized bench for alu_vector_responder checked against a queue-based reference model.
// Build with ALU_RESP_CHECK_EN defined to also check RespMismatch/ErrCount.
module tb_alu_vector_responder;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_vector_responder_if #(.TAG_W(TAG_W)) bus ();

    alu_vector_responder #(.RESP_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        bit          mm;
        int          vis;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   err_model = 0;

    logic        o_rv, o_rd, e_rv, e_rd, o_mm, e_mm;
    logic [31:0] o_data, e_data;
    logic [7:0]  o_tag, e_tag;
    bit          acc, pop;

    logic [6:0] ops [10] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b0000011, 7'b1100011, 7'b1111111};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU built directly from the RV32 instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] f, input logic t,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] sr;
        sh = b[4:0];
        if (op == 7'b0110011 || op == 7'b0010011) begin
            case (f)
                3'd0: return (op == 7'b0110011 && t) ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: begin
                    sr = a >> sh;
                    if (t && a[31]) sr = sr | ~(32'hFFFF_FFFF >> sh);
                    return sr;
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        if (op == 7'b0110111) return b;
        if (op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111 || op == 7'b1100011 ||
            op == 7'b0000011 || op == 7'b0100011) return a + b;
        return 32'd0;
    endfunction

    task automatic rand_req(output logic [6:0] op, output logic [2:0] f, output logic t,
                            output logic [31:0] a, output logic [31:0] b);
        op = ops[$urandom_range(0, 9)];
        f  = 3'($urandom);
        t  = 1'($urandom);
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    endtask

    // One clock cycle: sample outputs and model predictions at the negedge, drive inputs,
    // cross the posedge, update the model, return to the next negedge.
    task automatic step(input bit v, input logic [6:0] op, input logic [2:0] f, input logic t,
                        input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                        input bit rr, input bit corrupt);
        logic [31:0] r;
        int c0;
        c0     = cyc;
        o_rv   = bus.resp_valid;
        o_rd   = bus.req_ready;
        o_data = bus.resp_data;
        o_tag  = bus.resp_tag;
        e_rd   = (exp_q.size() < DEPTH);
        e_rv   = (exp_q.size() > 0) && (exp_q[0].vis <= c0);
        e_data = e_rv ? exp_q[0].data : 32'd0;
        e_tag  = e_rv ? exp_q[0].tag : 8'd0;
        e_mm   = e_rv && exp_q[0].mm;
        o_mm   = 1'b0;
        r = ref_alu(op, f, t, a, b);
        bus.req_valid           = v;
        bus.req_opcode          = op;
        bus.req_funct           = f;
        bus.req_add_rshift_type = t;
        bus.req_a               = a;
        bus.req_b               = b;
        bus.req_tag             = tag;
        bus.resp_ready          = rr;
`ifdef ALU_RESP_CHECK_EN
        bus.req_expected = corrupt ? ~r : r;
        o_mm             = bus.resp_mismatch;
`endif
        acc = v && e_rd;
        pop = rr && e_rv;
        @(posedge clk);
        if (pop) begin
            $display("resp tag=%h data=%h", o_tag, o_data);
            if (exp_q[0].mm && err_model < 65535) err_model++;
            void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back('{r, tag, corrupt, c0 + 2});
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_funct = '0; bus.req_add_rshift_type = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
`ifdef ALU_RESP_CHECK_EN
        bus.req_expected = '0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL reset_hold resp_valid=%b want 0", bus.resp_valid);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL reset_release resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready);
        else passed++;
`ifdef ALU_RESP_CHECK_EN
        checks++;
        if (bus.err_count !== 16'd0) $display("FAIL reset_errcount got %0d want 0", bus.err_count);
        else passed++;
`endif
        exp_q.delete();
        err_model = 0;
    endtask

    task automatic test_single_add();
        int acc_s = -1;
        int got_s = -1;
        for (int s = 0; s < 10 && got_s < 0; s++) begin
            step(s == 0, 7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 8'h11, 1'b1, 1'b0);
            checks++;
            if (o_rv !== e_rv || o_rd !== e_rd || (e_rv && (o_data !== e_data || o_tag !== e_tag)))
                $display("FAIL add_cycle cyc=%0d got rv=%b rdy=%b data=%h tag=%h want rv=%b rdy=%b data=%h tag=%h",
                         cyc, o_rv, o_rd, o_data, o_tag, e_rv, e_rd, e_data, e_tag);
            else passed++;
            if (acc) acc_s = s;
            if (pop) begin
                got_s = s;
                checks++;
                if (o_data !== 32'h0000_000C || o_tag !== 8'h11)
                    $display("FAIL add_result got data=%h tag=%h want 0000000c/11", o_data, o_tag);
                else passed++;
            end
        end
        checks++;
        if (got_s - acc_s != 2 || got_s < 0) $display("FAIL add_latency got %0d want 2", got_s - acc_s);
        else passed++;
    endtask

    task automatic test_sub_sra();
        logic [31:0] ta [2] = '{32'd5, 32'h8000_0000};
        logic [31:0] tb [2] = '{32'd7, 32'd4};
        logic [2:0]  tf [2] = '{3'd0, 3'd5};
        logic [31:0] tw [2] = '{32'hFFFF_FFFE, 32'hF800_0000};
        for (int k = 0; k < 2; k++) begin
            bit got = 0;
            for (int s = 0; s < 10 && !got; s++) begin
                step(s == 0, 7'b0110011, tf[k], 1'b1, ta[k], tb[k], 8'(8'h30 + k), 1'b1, 1'b0);
                checks++;
                if (o_rv !== e_rv || o_rd !== e_rd || (e_rv && (o_data !== e_data || o_tag !== e_tag)))
                    $display("FAIL subsra_cycle cyc=%0d got rv=%b data=%h want rv=%b data=%h",
                             cyc, o_rv, o_data, e_rv, e_data);
                else passed++;
                if (pop) begin
                    got = 1;
                    checks++;
                    if (o_data !== tw[k]) $display("FAIL subsra_result[%0d] got %h want %h", k, o_data, tw[k]);
                    else passed++;
                end
            end
            checks++;
            if (!got) $display("FAIL subsra_timeout[%0d] got no response want one", k);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] op; logic [2:0] f; logic t; logic [31:0] a, b;
        int sent = 0, acc_stalled = 0;
        logic [7:0] next_tag = 8'd0;
        rand_req(op, f, t, a, b);
        for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
            step(sent < 6, op, f, t, a, b, 8'(sent), c >= 10, 1'b0);
            checks++;
            if (o_rv !== e_rv || o_rd !== e_rd || (e_rv && (o_data !== e_data || o_tag !== e_tag)))
                $display("FAIL bp_cycle cyc=%0d got rv=%b rdy=%b data=%h tag=%h want rv=%b rdy=%b data=%h tag=%h",
                         cyc, o_rv, o_rd, o_data, o_tag, e_rv, e_rd, e_data, e_tag);
            else passed++;
            if (acc) begin
                if (c < 10) acc_stalled++;
                sent++;
                rand_req(op, f, t, a, b);
            end
            if (pop) begin
                checks++;
                if (o_tag !== next_tag) $display("FAIL bp_order got tag=%h want %h", o_tag, next_tag);
                else passed++;
                next_tag++;
            end
        end
        checks++;
        if (acc_stalled != 4) $display("FAIL bp_credit got %0d accepts while stalled want 4", acc_stalled);
        else passed++;
        checks++;
        if (sent != 6 || next_tag != 8'd6) $display("FAIL bp_drain got sent=%0d resp=%0d want 6/6", sent, next_tag);
        else passed++;
    endtask

    task automatic test_stream();
        logic [6:0] op; logic [2:0] f; logic t; logic [31:0] a, b;
        int n_acc = 0, n_pop = 0, steps = 0;
        rand_req(op, f, t, a, b);
        while (n_pop < 100 && steps < 200) begin
            step(n_acc < 100, op, f, t, a, b, 8'(n_acc), 1'b1, 1'b0);
            checks++;
            if (o_rv !== e_rv || o_rd !== e_rd || (e_rv && (o_data !== e_data || o_tag !== e_tag)))
                $display("FAIL stream_cycle cyc=%0d got rv=%b rdy=%b data=%h tag=%h want rv=%b rdy=%b data=%h tag=%h",
                         cyc, o_rv, o_rd, o_data, o_tag, e_rv, e_rd, e_data, e_tag);
            else passed++;
            if (acc) begin
                n_acc++;
                rand_req(op, f, t, a, b);
            end
            if (pop) n_pop++;
            steps++;
        end
        checks++;
        if (n_acc != 100 || n_pop != 100 || steps != 102)
            $display("FAIL stream_rate got acc=%0d resp=%0d cycles=%0d want 100/100/102", n_acc, n_pop, steps);
        else passed++;
    endtask

    task automatic test_mid_reset();
        bit corrupt_en = 1'b0;
        bit got = 0;
`ifdef ALU_RESP_CHECK_EN
        corrupt_en = 1'b1;
`endif
        for (int i = 0; i < 3; i++)
            step(1'b1, 7'b0110011, 3'd0, 1'b0, $urandom, $urandom, 8'(8'h20 + i), 1'b0, 1'b0);
        repeat (2) step(1'b0, 7'b0, 3'd0, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (bus.resp_valid !== 1'b1 || exp_q.size() != 3)
            $display("FAIL midrst_queued got resp_valid=%b model=%0d want 1/3", bus.resp_valid, exp_q.size());
        else passed++;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL midrst_async got resp_valid=%b want 0", bus.resp_valid);
        else passed++;
        exp_q.delete();
        err_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL midrst_release got rv=%b rdy=%b want 0/1", bus.resp_valid, bus.req_ready);
        else passed++;
        for (int s = 0; s < 10 && !got; s++) begin
            step(s == 0, 7'b0110011, 3'd0, 1'b0, 32'd100, 32'd23, 8'h5A, 1'b1, corrupt_en);
            checks++;
            if (o_rv !== e_rv || (e_rv && (o_data !== e_data || o_tag !== e_tag)))
                $display("FAIL midrst_cycle cyc=%0d got rv=%b data=%h tag=%h want rv=%b data=%h tag=%h",
                         cyc, o_rv, o_data, o_tag, e_rv, e_data, e_tag);
            else passed++;
            if (pop) begin
                got = 1;
                checks++;
                if (o_data !== 32'd123 || o_tag !== 8'h5A)
                    $display("FAIL midrst_result got data=%h tag=%h want 0000007b/5a", o_data, o_tag);
                else passed++;
`ifdef ALU_RESP_CHECK_EN
                checks++;
                if (o_mm !== e_mm || e_mm !== 1'b1) $display("FAIL mismatch_flag got %b want 1", o_mm);
                else passed++;
`endif
            end
        end
        checks++;
        if (!got) $display("FAIL midrst_timeout got no response want one");
        else passed++;
`ifdef ALU_RESP_CHECK_EN
        checks++;
        if (bus.err_count !== 16'(err_model) || err_model != 1)
            $display("FAIL errcount got %0d want 1", bus.err_count);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_sra();
        test_backpressure();
        test_stream();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
